uvme_obi_st_arb: RTL and testbench

- Round-robin arbiter that shares one OBI slave port among NUM_MSTRS OBI master ports. Used in the OBI self-test environment between agent-driven masters and a single slave.
- Handles address-phase arbitration with OBI stability rules.
- Tracks the owner of each outstanding transaction in an in-order ID FIFO and routes each R-channel response back to its owner.

---
 rtl/uvme_obi_st_arb_pkg.sv | 21 ++
 rtl/uvme_obi_st_arb_fifo.sv | 84 ++++++++
 rtl/uvme_obi_st_arb.sv | 202 ++++++++++++++++++++
 tb/tb_uvme_obi_st_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvme_obi_st_arb_pkg.sv
// ---------------------------------------------------------------------------
// uvme_obi_st_arb_pkg
// Shared types and helpers for the OBI self-test round-robin arbiter.
//   uvme_obi_st_arb_state_t   : address-phase FSM states (IDLE, HOLD)
//   UVME_OBI_ST_ARB_GNT_CNT_W : width of each per-master grant counter
//   idx_w()                   : index width for n items (at least 1 bit)
// ---------------------------------------------------------------------------
package uvme_obi_st_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } uvme_obi_st_arb_state_t;

    localparam int UVME_OBI_ST_ARB_GNT_CNT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uvme_obi_st_arb_fifo.sv
// ---------------------------------------------------------------------------
// uvme_obi_st_arb_fifo
// In-order owner-ID FIFO. Remembers which master owns each outstanding
// transaction so that responses can be routed back.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (FIFO -> empty)
//   push, push_id  enqueue an owner ID
//   pop            dequeue the head entry
//   full, empty    occupancy flags
//   head_id        owner ID at the head
// A push is accepted while full only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module uvme_obi_st_arb_fifo
    import uvme_obi_st_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head_id
);

    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head_id = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uvme_obi_st_arb.sv
// ---------------------------------------------------------------------------
// uvme_obi_st_arb
// Round-robin arbiter sharing one OBI slave port among NUM_MSTRS masters.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   m_req/m_gnt                        per-master address handshake
//   m_addr/m_we/m_be/m_wdata           packed per-master A-channel
//   m_rvalid/m_rready                  per-master R handshake
//   m_rdata/m_err                      R data/error, broadcast to all masters
//   s_req/s_gnt, s_addr/s_we/s_be/s_wdata  muxed slave A-channel
//   s_rvalid/s_rready/s_rdata/s_err    slave R-channel
//   proto_err                          sticky: response with nothing outstanding
//   gnt_cnt (UVME_OBI_ST_ARB_GNT_CNT_EN only) per-master saturating grant counts
//
// state | meaning
// IDLE  | pick a requester combinationally, grant same cycle if slave ready
// HOLD  | slave stalled; keep the latched master's request stable until s_gnt
// ---------------------------------------------------------------------------
module uvme_obi_st_arb
    import uvme_obi_st_arb_pkg::*;
#(
    parameter int NUM_MSTRS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_MSTRS-1:0]             m_req,
    output logic [NUM_MSTRS-1:0]             m_gnt,
    input  logic [NUM_MSTRS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_MSTRS-1:0]             m_we,
    input  logic [NUM_MSTRS*DATA_WIDTH/8-1:0] m_be,
    input  logic [NUM_MSTRS*DATA_WIDTH-1:0]  m_wdata,
    output logic [NUM_MSTRS-1:0]             m_rvalid,
    input  logic [NUM_MSTRS-1:0]             m_rready,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic                             s_req,
    input  logic                             s_gnt,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_we,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic                             s_rvalid,
    output logic                             s_rready,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    input  logic                             s_err,
    output logic                             proto_err
`ifdef UVME_OBI_ST_ARB_GNT_CNT_EN
    ,
    output logic [NUM_MSTRS*UVME_OBI_ST_ARB_GNT_CNT_W-1:0] gnt_cnt
`endif
);

    localparam int ID_W = idx_w(NUM_MSTRS);
    localparam int BE_W = DATA_WIDTH / 8;

    uvme_obi_st_arb_state_t state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] hold_sel_q, hold_sel_d;
    logic [ID_W-1:0] arb_sel, sel, cand, head_id;
    logic            arb_found, fifo_full, fifo_empty, push, pop;
    logic            proto_err_q, proto_err_d;

    // Cyclic search starting at rr_ptr; cand walks rr_ptr, rr_ptr+1, ... mod N.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_MSTRS; k++) begin
            for (int i = 0; i < NUM_MSTRS; i++) begin
                if (!arb_found && m_req[i] && (cand == ID_W'(i))) begin
                    arb_found = 1'b1;
                    arb_sel   = cand;
                end
            end
            cand = (cand == ID_W'(NUM_MSTRS - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_sel_d = hold_sel_q;
        sel        = arb_sel;
        s_req      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pop in this cycle frees a slot, so a full FIFO can still accept.
                s_req = arb_found && (!fifo_full || pop);
                if (s_req && !s_gnt) begin
                    state_d    = HOLD;
                    hold_sel_d = arb_sel;
                end
            end
            HOLD: begin
                sel   = hold_sel_q;
                s_req = 1'b1;
                if (s_gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Keeps the slave request low while reset is held, independent of inputs.
        s_req = s_req && reset_n;
    end

    assign push     = s_req && s_gnt;
    assign rr_ptr_d = !push ? rr_ptr_q
                    : (sel == ID_W'(NUM_MSTRS - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        m_gnt   = '0;
        s_addr  = '0;
        s_we    = 1'b0;
        s_be    = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_MSTRS; i++) begin
            if (sel == ID_W'(i)) begin
                m_gnt[i] = push;
                s_addr   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_we     = m_we[i];
                s_be     = m_be[i*BE_W +: BE_W];
                s_wdata  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // With nothing outstanding the slave is always ready so a stray response
    // drains immediately and only flags proto_err.
    always_comb begin
        s_rready = fifo_empty;
        m_rvalid = '0;
        for (int i = 0; i < NUM_MSTRS; i++) begin
            if (!fifo_empty && (head_id == ID_W'(i))) begin
                m_rvalid[i] = s_rvalid;
                s_rready    = m_rready[i];
            end
        end
    end

    assign pop         = s_rvalid && s_rready && !fifo_empty;
    assign proto_err_d = proto_err_q || (s_rvalid && fifo_empty);
    assign proto_err   = proto_err_q;
    assign m_rdata     = s_rdata;
    assign m_err       = s_err;

    uvme_obi_st_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .push_id (sel),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head_id (head_id)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_sel_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_sel_q  <= hold_sel_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef UVME_OBI_ST_ARB_GNT_CNT_EN
    logic [NUM_MSTRS-1:0][UVME_OBI_ST_ARB_GNT_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        for (int i = 0; i < NUM_MSTRS; i++) begin
            if (m_gnt[i] && (gnt_cnt_q[i] != '1)) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt = gnt_cnt_q;
`else
    // Grant statistics compiled out; no counters exist in this build.
`endif

endmodule

// File: tb/tb_uvme_obi_st_arb.sv
module tb_uvme_obi_st_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic [N-1:0]    m_req, m_gnt, m_we, m_rvalid, m_rready;
    logic [N*AW-1:0] m_addr;
    logic [N*BW-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req, s_gnt, s_we;
    logic [AW-1:0]   s_addr;
    logic [BW-1:0]   s_be;
    logic [DW-1:0]   s_wdata;
    logic            s_rvalid, s_rready, s_err;
    logic [DW-1:0]   s_rdata;
    logic            proto_err;
`ifdef UVME_OBI_ST_ARB_GNT_CNT_EN
    logic [N*16-1:0] gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_o;

    typedef struct {
        int          owner;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    uvme_obi_st_arb #(
        .NUM_MSTRS       (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_gnt     (m_gnt),
        .m_addr    (m_addr),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_wdata   (m_wdata),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s_req     (s_req),
        .s_gnt     (s_gnt),
        .s_addr    (s_addr),
        .s_we      (s_we),
        .s_be      (s_be),
        .s_wdata   (s_wdata),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_err     (s_err),
        .proto_err (proto_err)
`ifdef UVME_OBI_ST_ARB_GNT_CNT_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        return N'(1) << o;
    endfunction

    task automatic set_a(input int i, input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] wd);
        m_addr[i*AW +: AW]  = a;
        m_we[i]             = we;
        m_be[i*BW +: BW]    = '1;
        m_wdata[i*DW +: DW] = wd;
    endtask

    task automatic sb_push(input int owner, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.owner = owner;
        e.rdata = rd;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Returns a response for the oldest expected transaction; the owner's
    // ready is taken from rr for hold cycles, then all masters become ready.
    task automatic respond(input logic [N-1:0] rr, input int hold);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow: observed=empty expected=entry");
            return;
        end
        e        = exp_q.pop_front();
        s_rvalid = 1'b1;
        s_rdata  = e.rdata;
        s_err    = e.err;
        m_rready = rr;
        for (int c = 0; c < hold; c++) begin
            settle();
            chk("bp_s_rready", 64'(s_rready), 64'(rr[e.owner]));
            chk("bp_m_rvalid", 64'(m_rvalid), 64'(onehot(e.owner)));
            chk("bp_m_rdata", 64'(m_rdata), 64'(e.rdata));
            tick();
        end
        m_rready = '1;
        settle();
        chk("r_m_rvalid", 64'(m_rvalid), 64'(onehot(e.owner)));
        chk("r_m_rdata", 64'(m_rdata), 64'(e.rdata));
        chk("r_m_err", 64'(m_err), 64'(e.err));
        chk("r_s_rready", 64'(s_rready), 64'(1));
        tick();
        s_rvalid = 1'b0;
        s_err    = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        m_req    = '0;
        m_addr   = '0;
        m_we     = '0;
        m_be     = '0;
        m_wdata  = '0;
        m_rready = '1;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_err    = 1'b0;

        #2;
        chk("rst_s_req", 64'(s_req), 64'(0));
        chk("rst_m_gnt", 64'(m_gnt), 64'(0));
        chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        tick();
        reset_n = 1'b1;

        // Single master write, zero-latency grant, response to master 0 only.
        set_a(0, 32'h0000_0100, 1'b1, 32'h1234_5678);
        m_req = 2'b01;
        s_gnt = 1'b1;
        sb_push(0, 32'hDEAD_BEEF, 1'b0);
        settle();
        chk("t1_m_gnt", 64'(m_gnt), 64'(2'b01));
        chk("t1_s_req", 64'(s_req), 64'(1));
        chk("t1_s_addr", 64'(s_addr), 64'(32'h100));
        chk("t1_s_we", 64'(s_we), 64'(1));
        chk("t1_s_wdata", 64'(s_wdata), 64'(32'h1234_5678));
        tick();
        m_req = '0;
        s_gnt = 1'b0;
        respond(2'b11, 0);
        settle();
        chk("t1_rvalid_idle", 64'(m_rvalid), 64'(0));
        chk("t1_proto_err", 64'(proto_err), 64'(0));
        tick();

        // Both masters requesting with s_gnt high; rr_ptr is 1 after the first grant.
        m_req = 2'b11;
        s_gnt = 1'b1;
        for (int k = 0; k < MO; k++) begin
            exp_o = (k % 2 == 0) ? 1 : 0;
            set_a(0, 32'h0000_0200 + 32'(k * 4), 1'b0, '0);
            set_a(1, 32'h0000_0300 + 32'(k * 4), 1'b0, '0);
            sb_push(exp_o, 32'hA000_0000 + 32'(k), k == 2);
            settle();
            chk("rr_m_gnt", 64'(m_gnt), 64'(onehot(exp_o)));
            chk("rr_s_addr", 64'(s_addr),
                64'((exp_o == 0 ? 32'h200 : 32'h300) + 32'(k * 4)));
            tick();
        end
        settle();
        chk("full_s_req", 64'(s_req), 64'(0));
        chk("full_m_gnt", 64'(m_gnt), 64'(0));
        tick();

        // Full FIFO: pop of the head and a new grant in the same cycle.
        begin
            exp_t e;
            e        = exp_q.pop_front();
            s_rvalid = 1'b1;
            s_rdata  = e.rdata;
            s_err    = e.err;
            sb_push(1, 32'hA000_0004, 1'b0);
            settle();
            chk("pp_m_gnt", 64'(m_gnt), 64'(2'b10));
            chk("pp_m_rvalid", 64'(m_rvalid), 64'(onehot(e.owner)));
            chk("pp_m_rdata", 64'(m_rdata), 64'(e.rdata));
            tick();
        end
        s_rvalid = 1'b0;
        settle();
        chk("pp_still_full", 64'(s_req), 64'(0));
        tick();
        m_req = '0;
        s_gnt = 1'b0;

        // Drain: head owner 0 back-pressures for 2 cycles, then the rest.
        respond(2'b10, 2);
        respond(2'b11, 0);
        respond(2'b11, 0);
        respond(2'b11, 0);

        // Master 1 stalled by the slave while master 0 also requests.
        set_a(1, 32'h0000_0400, 1'b1, 32'h0000_1111);
        set_a(0, 32'h0000_0500, 1'b0, '0);
        m_req = 2'b10;
        s_gnt = 1'b0;
        settle();
        chk("hold0_s_req", 64'(s_req), 64'(1));
        chk("hold0_s_addr", 64'(s_addr), 64'(32'h400));
        chk("hold0_m_gnt", 64'(m_gnt), 64'(0));
        tick();
        m_req = 2'b11;
        settle();
        chk("hold1_s_req", 64'(s_req), 64'(1));
        chk("hold1_s_addr", 64'(s_addr), 64'(32'h400));
        chk("hold1_m_gnt", 64'(m_gnt), 64'(0));
        tick();
        m_req = 2'b01;
        settle();
        chk("hold2_s_req", 64'(s_req), 64'(1));
        chk("hold2_s_addr", 64'(s_addr), 64'(32'h400));
        chk("hold2_s_we", 64'(s_we), 64'(1));
        tick();
        s_gnt = 1'b1;
        sb_push(1, 32'hB000_0001, 1'b0);
        settle();
        chk("hold_gnt1", 64'(m_gnt), 64'(2'b10));
        chk("hold_gnt1_addr", 64'(s_addr), 64'(32'h400));
        tick();
        sb_push(0, 32'hB000_0000, 1'b0);
        settle();
        chk("hold_gnt0", 64'(m_gnt), 64'(2'b01));
        chk("hold_gnt0_addr", 64'(s_addr), 64'(32'h500));
        tick();
        m_req = '0;
        s_gnt = 1'b0;
        respond(2'b11, 0);
        respond(2'b11, 0);

        // Stray response with nothing outstanding.
        s_rvalid = 1'b1;
        s_rdata  = 32'h0BAD_0BAD;
        settle();
        chk("stray_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("stray_s_rready", 64'(s_rready), 64'(1));
        tick();
        s_rvalid = 1'b0;
        settle();
        chk("stray_proto_err", 64'(proto_err), 64'(1));
        tick();
        settle();
        chk("sticky_proto_err", 64'(proto_err), 64'(1));
        tick();

        // Two outstanding plus a held request, then asynchronous reset.
        m_req = 2'b01;
        s_gnt = 1'b1;
        settle();
        chk("pre_rst_gnt_a", 64'(m_gnt), 64'(2'b01));
        tick();
        settle();
        chk("pre_rst_gnt_b", 64'(m_gnt), 64'(2'b01));
        tick();
        m_req = 2'b10;
        s_gnt = 1'b0;
        settle();
        chk("pre_rst_s_req", 64'(s_req), 64'(1));
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_s_req", 64'(s_req), 64'(0));
        chk("arst_m_gnt", 64'(m_gnt), 64'(0));
        chk("arst_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("arst_proto_err", 64'(proto_err), 64'(0));
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        m_req   = '0;

        // Late response after reset has no owner.
        s_rvalid = 1'b1;
        s_rdata  = 32'h1A7E_1A7E;
        settle();
        chk("late_m_rvalid", 64'(m_rvalid), 64'(0));
        tick();
        s_rvalid = 1'b0;
        settle();
        chk("late_proto_err", 64'(proto_err), 64'(1));
        tick();

        // Arbitration restarts at master 0.
        set_a(0, 32'h0000_0600, 1'b0, '0);
        set_a(1, 32'h0000_0700, 1'b0, '0);
        m_req = 2'b11;
        s_gnt = 1'b1;
        sb_push(0, 32'hC000_0000, 1'b0);
        settle();
        chk("post_rst_gnt", 64'(m_gnt), 64'(2'b01));
        chk("post_rst_addr", 64'(s_addr), 64'(32'h600));
        tick();
        m_req = '0;
        s_gnt = 1'b0;
        respond(2'b11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
